// File: rtl/riscv_defs.sv
// Shared definitions for the writeback path.
//   XLEN       - datapath width
//   REG_ADDR_W - register index width
//   NUM_REGS   - architectural register count (width of the busy scoreboard)
//   ZERO_REG   - hard-wired zero register index
//   wb_src_e   - which source drives the register-file write port in a cycle
package riscv_defs;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_LOAD
    } wb_src_e;

endpackage

// File: rtl/wb_load_queue.sv
// In-order load queue for the writeback stage.
// Entries are allocated at the tail on issue, filled in order at the fill
// pointer as responses return, and retired from the head once filled.
//   clk, rst     - clock, asynchronous active-high reset
//   issue_valid  - allocate an entry (ignored while full)
//   issue_rd     - destination register of the issued load
//   resp_valid   - load data returning for the oldest unfilled entry
//   resp_data    - returning load data
//   pop          - retire the head entry (only meaningful with head_ready)
//   head_ready   - head entry is valid and holds its data
//   head_rd      - destination register of the head entry
//   head_data    - data of the head entry
//   issue_ready  - queue not full (from registered count)
//   count        - occupied entries
//   entry_valid  - per-entry valid flags, for the busy scoreboard
//   entry_rd     - per-entry destination registers, for the busy scoreboard
module wb_load_queue
    import riscv_defs::*;
#(
    parameter int unsigned XLEN  = riscv_defs::XLEN,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic [REG_ADDR_W-1:0]          issue_rd,
    input  logic                           resp_valid,
    input  logic [XLEN-1:0]                resp_data,
    input  logic                           pop,
    output logic                           head_ready,
    output logic [REG_ADDR_W-1:0]          head_rd,
    output logic [XLEN-1:0]                head_data,
    output logic                           issue_ready,
    output logic [CW-1:0]                  count,
    output logic [DEPTH-1:0]               entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] filled;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0] data_q [DEPTH];

    logic issue_fire;
    logic pop_fire;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never lets a new issue into a full queue.
    assign issue_ready = (count < CW'(DEPTH));
    assign issue_fire  = issue_valid && issue_ready;

    assign head_ready  = valid[head_ptr] && filled[head_ptr];
    assign pop_fire    = pop && head_ready;
    assign head_rd     = rd_q[head_ptr];
    assign head_data   = data_q[head_ptr];

    assign entry_valid = valid;
    assign entry_rd    = rd_q;

    // Issue writes at the tail, responses at the fill pointer and pops at the
    // head. The three never target the same entry in a legal cycle: the tail
    // equals the head only when empty or full, and the fill pointer only
    // reaches the tail when no unfilled entry remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            valid    <= '0;
            filled   <= '0;
            rd_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (issue_fire) begin
                valid[tail_ptr]  <= 1'b1;
                filled[tail_ptr] <= 1'b0;
                rd_q[tail_ptr]   <= issue_rd;
                tail_ptr         <= tail_ptr + PW'(1);
            end
            if (resp_valid) begin
                filled[fill_ptr] <= 1'b1;
                data_q[fill_ptr] <= resp_data;
                fill_ptr         <= fill_ptr + PW'(1);
            end
            if (pop_fire) begin
                valid[head_ptr] <= 1'b0;
                head_ptr        <= head_ptr + PW'(1);
            end
            count <= count + CW'(issue_fire) - CW'(pop_fire);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and in-order load
// responses onto the register file's single write port, and publishes a
// per-register busy scoreboard for decode.
//   clk, rst        - clock, asynchronous active-high reset
//   alu_valid       - ALU result present this cycle (always has priority)
//   alu_rd, alu_wd  - ALU destination register and result
//   ld_issue_valid  - load issued this cycle, allocates a queue entry
//   ld_issue_rd     - load destination register
//   ld_issue_ready  - load queue not full
//   ld_resp_valid   - load data returning, in issue order
//   ld_resp_data    - returning load data
//   rf_we/rf_rd/rf_wd - registered register-file write port
//   busy            - bit i set while a write to xi is still pending
//   lq_count        - occupied load-queue entries
module wb_arbiter
    import riscv_defs::*;
#(
    parameter int unsigned XLEN     = riscv_defs::XLEN,
    parameter int unsigned LQ_DEPTH = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [XLEN-1:0]           alu_wd,
    input  logic                      ld_issue_valid,
    input  logic [4:0]                ld_issue_rd,
    output logic                      ld_issue_ready,
    input  logic                      ld_resp_valid,
    input  logic [XLEN-1:0]           ld_resp_data,
    output logic                      rf_we,
    output logic [4:0]                rf_rd,
    output logic [XLEN-1:0]           rf_wd,
    output logic [31:0]               busy,
    output logic [$clog2(LQ_DEPTH):0] lq_count
);

    logic                                head_ready;
    logic [REG_ADDR_W-1:0]               head_rd;
    logic [XLEN-1:0]                     head_data;
    logic [LQ_DEPTH-1:0]                 entry_valid;
    logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
    logic                                pop;
    wb_src_e                             sel;

    wb_load_queue #(
        .XLEN  (XLEN),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (ld_issue_valid),
        .issue_rd    (ld_issue_rd),
        .resp_valid  (ld_resp_valid),
        .resp_data   (ld_resp_data),
        .pop         (pop),
        .head_ready  (head_ready),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .issue_ready (ld_issue_ready),
        .count       (lq_count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // ALU always wins; a filled load head waits as long as the ALU is busy.
    always_comb begin
        sel = WB_SRC_NONE;
        if (alu_valid) begin
            sel = WB_SRC_ALU;
        end else if (head_ready) begin
            sel = WB_SRC_LOAD;
        end
    end

    assign pop = (sel == WB_SRC_LOAD);

    // Writes to x0 still occupy the port slot but never assert the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
        end else begin
            case (sel)
                WB_SRC_ALU: begin
                    rf_we <= (alu_rd != ZERO_REG);
                    rf_rd <= alu_rd;
                    rf_wd <= alu_wd;
                end
                WB_SRC_LOAD: begin
                    rf_we <= (head_rd != ZERO_REG);
                    rf_rd <= head_rd;
                    rf_wd <= head_data;
                end
                default: begin
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard from state only: every queued load (filled or not) plus the
    // write sitting in the output register, which the file has not seen yet.
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (entry_valid[i]) begin
                busy[entry_rd[i]] = 1'b1;
            end
        end
        if (rf_we) begin
            busy[rf_rd] = 1'b1;
        end
        busy[ZERO_REG] = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int LQ = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [31:0] busy;
    logic [2:0]  lq_count;

    wb_arbiter #(
        .XLEN     (32),
        .LQ_DEPTH (LQ)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_wd         (alu_wd),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_wd          (rf_wd),
        .busy           (busy),
        .lq_count       (lq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: list of outstanding loads, oldest first, plus the
    // expected register-file port.
    typedef struct {
        logic [4:0]  rd;
        bit          filled;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_wd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (q[i]) b[q[i].rd] = 1'b1;
        if (m_we) b[m_rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    function automatic bit has_unfilled();
        foreach (q[i]) if (!q[i].filled) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input logic av, input logic [4:0] ar, input logic [31:0] aw,
                              input logic iv, input logic [4:0] ir,
                              input logic rv, input logic [31:0] rdat);
        bit do_pop;
        bit done;
        do_pop = !av && (q.size() > 0) && q[0].filled;
        if (av) begin
            m_we = (ar != 0); m_rd = ar; m_wd = aw;
        end else if (do_pop) begin
            m_we = (q[0].rd != 0); m_rd = q[0].rd; m_wd = q[0].data;
        end else begin
            m_we = 1'b0;
        end
        if (rv) begin
            done = 1'b0;
            foreach (q[i]) begin
                if (!done && !q[i].filled) begin
                    q[i].filled = 1'b1;
                    q[i].data   = rdat;
                    done        = 1'b1;
                end
            end
        end
        if (do_pop) void'(q.pop_front());
        if (iv) q.push_back('{rd: ir, filled: 1'b0, data: 32'h0});
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0; m_rd = '0; m_wd = '0;
    endtask

    // Drive one cycle of inputs, advance through the edge, update the model.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] aw,
                        input logic iv, input logic [4:0] ir,
                        input logic rv, input logic [31:0] rdat);
        alu_valid      = av;
        alu_rd         = ar;
        alu_wd         = aw;
        ld_issue_valid = iv;
        ld_issue_rd    = ir;
        ld_resp_valid  = rv;
        ld_resp_data   = rdat;
        @(posedge clk);
        model_edge(av, ar, aw, iv, ir, rv, rdat);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("rf_we",    rf_we,          m_we);
            chk("rf_rd",    rf_rd,          m_rd);
            chk("rf_wd",    rf_wd,          m_wd);
            chk("busy",     busy,           model_busy());
            chk("lq_count", lq_count,       q.size());
            chk("ready",    ld_issue_ready, q.size() < LQ);
        end
    end

    initial begin
        logic        av, iv, rv;
        logic [4:0]  ar, ir;
        logic [31:0] aw, rdat;
        logic [31:0] mb;
        int          guard;

        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        ld_issue_valid = 0; ld_issue_rd = 0;
        ld_resp_valid = 0; ld_resp_data = 0;
        #12;
        chk("reset_rf_we",    rf_we,          1'b0);
        chk("reset_busy",     busy,           32'h0);
        chk("reset_count",    lq_count,       3'd0);
        chk("reset_ready",    ld_issue_ready, 1'b1);
        rst = 1'b0;
        cmp_en = 1'b1;

        // ALU only
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h0);
        chk("t1_we",   rf_we, 1'b1);
        chk("t1_rd",   rf_rd, 5'd5);
        chk("t1_wd",   rf_wd, 32'hDEADBEEF);
        chk("t1_busy", busy,  32'h0000_0020);
        idle();
        chk("t1_we_off", rf_we, 1'b0);
        chk("t1_busy_off", busy, 32'h0);

        // Load path to x7
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 32'h0);
        chk("t2_busy",  busy,     32'h0000_0080);
        chk("t2_count", lq_count, 3'd1);
        idle();
        idle();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h12345678);
        chk("t2_no_early_we", rf_we, 1'b0);
        idle();
        chk("t2_we",    rf_we,    1'b1);
        chk("t2_rd",    rf_rd,    5'd7);
        chk("t2_wd",    rf_wd,    32'h12345678);
        chk("t2_count0", lq_count, 3'd0);
        chk("t2_busy_rf", busy,   32'h0000_0080);
        idle();
        chk("t2_busy_clr", busy, 32'h0);

        // Contention: filled head x9 waits behind three ALU results
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h99);
        step(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 1'b0, 32'h0);
        chk("t3_rd1", rf_rd, 5'd1);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0, 32'h0);
        chk("t3_rd2", rf_rd, 5'd2);
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 32'h0);
        chk("t3_rd3", rf_rd, 5'd3);
        chk("t3_wd3", rf_wd, 32'h33);
        idle();
        chk("t3_we9", rf_we, 1'b1);
        chk("t3_rd9", rf_rd, 5'd9);
        chk("t3_wd9", rf_wd, 32'h99);
        idle();

        // Full queue
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'(10 + i), 1'b0, 32'h0);
        chk("t4_full_ready", ld_issue_ready, 1'b0);
        chk("t4_full_count", lq_count,       3'd4);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA);
        chk("t4_still_full", ld_issue_ready, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hB);
        chk("t4_rd10", rf_rd, 5'd10);
        chk("t4_wdA",  rf_wd, 32'hA);
        chk("t4_ready_after_pop", ld_issue_ready, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hC);
        chk("t4_rd11", rf_rd, 5'd11);
        chk("t4_wdB",  rf_wd, 32'hB);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hD);
        chk("t4_rd12", rf_rd, 5'd12);
        idle();
        chk("t4_rd13", rf_rd, 5'd13);
        chk("t4_wdD",  rf_wd, 32'hD);
        idle();
        chk("t4_empty", lq_count, 3'd0);

        // Load to x0
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0);
        chk("t5_x0_busy", busy, 32'h0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h55);
        idle();
        chk("t5_x0_we",    rf_we,    1'b0);
        chk("t5_x0_busy2", busy,     32'h0);
        chk("t5_x0_count", lq_count, 3'd0);

        // Issue and response in the same cycle: data goes to the older entry
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 1'b0, 32'h0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 1'b1, 32'hAA);
        idle();
        chk("t5_ov_rd", rf_rd, 5'd14);
        chk("t5_ov_wd", rf_wd, 32'hAA);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hBB);
        idle();
        chk("t5_ov_rd2", rf_rd, 5'd15);
        chk("t5_ov_wd2", rf_wd, 32'hBB);
        idle();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'(16 + i), 1'b0, 32'h0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_we",    rf_we,          1'b0);
        chk("t6_busy",  busy,           32'h0);
        chk("t6_count", lq_count,       3'd0);
        chk("t6_ready", ld_issue_ready, 1'b1);
        model_reset();
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_no_write", rf_we, 1'b0);
        end

        // Randomized traffic within the protocol
        for (int n = 0; n < 3000; n++) begin
            mb   = model_busy();
            av   = ($urandom_range(0, 1) == 1);
            ar   = 5'($urandom_range(0, 31));
            aw   = $urandom;
            if (ar != 0 && mb[ar]) av = 1'b0;
            iv   = ($urandom_range(0, 2) == 0) && (q.size() < LQ);
            ir   = 5'($urandom_range(0, 31));
            rv   = ($urandom_range(0, 2) == 0) && has_unfilled();
            rdat = $urandom;
            step(av, ar, aw, iv, ir, rv, rdat);
        end

        // Drain
        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, has_unfilled(), $urandom);
            guard++;
        end
        chk("drain_count", lq_count, 3'd0);
        idle();
        chk("drain_busy", busy, 32'h0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file. It merges two result sources onto the file's single write port (we/rd/wd).
- Sources: single-cycle ALU results, and in-order load responses buffered in a small load queue.
- Keeps a per-register busy scoreboard so decode can stall reads of registers with writes still pending.

Parameters:
- XLEN, 32, data width.
- LQ_DEPTH, 4, load-queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  XLEN  ALU result.
- ld_issue_valid  in  1  load issued this cycle; allocates a queue entry.
- ld_issue_rd  in  5  load destination register.
- ld_issue_ready  out  1  queue not full.
- ld_resp_valid  in  1  load data returning (in issue order, no backpressure).
- ld_resp_data  in  XLEN  load data.
- rf_we  out  1  to register-file write enable (registered).
- rf_rd  out  5  to register-file destination (registered).
- rf_wd  out  XLEN  to register-file write data (registered).
- busy  out  32  scoreboard; bit i set means a write to xi is pending.
- lq_count  out  clog2(LQ_DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_rd=0, rf_wd=0.
  - Queue emptied: head, tail and fill pointers 0; count 0.
  - busy=0, ld_issue_ready=1.
  - In-flight loads are discarded; responses arriving after reset are protocol errors.
- Queue entry fields: {rd, filled, data}.
  - Issue writes an entry at the tail with filled=0.
  - Response writes data into the entry at the fill pointer, sets filled, and advances the fill pointer.
  - Pointers wrap modulo LQ_DEPTH.
- Writeback selection each cycle, registered into rf_* at the next posedge (1-cycle latency):
  1. If alu_valid: rf_we<=(alu_rd!=0), rf_rd<=alu_rd, rf_wd<=alu_wd. The queue does not pop.
  2. Else if the head entry is valid and filled: pop it; rf_we<=(head.rd!=0), rf_rd<=head.rd, rf_wd<=head.data.
  3. Else rf_we<=0; rf_rd and rf_wd hold their values.
- ALU always wins. A filled head waits while alu_valid is high; no starvation limit.
- Loads to x0 allocate and consume their response, but never assert rf_we.
- Load data that is ready on arrival still takes a full cycle in the queue:
  - Response at edge N fills the entry.
  - The entry pops into rf_* at edge N+1.
  - The register file writes at edge N+2.
- busy[i] for i!=0 is set if either:
  - any valid queue entry has rd==i (filled or not), or
  - rf_we && rf_rd==i (the write has not reached the file yet).
- busy[0] is always 0. busy is combinational from state only, not from inputs.
- ld_issue_ready = (count<LQ_DEPTH), from registered count.
  - When full, ready stays low even if a pop happens the same cycle (no fall-through).
- Count update: +1 on issue, -1 on pop; a simultaneous issue and pop leaves it unchanged.
- Same-cycle events:
  - Issue and response in the same cycle: the response fills the oldest unfilled entry, never the one being issued.
  - Response and pop on the same entry cannot coincide; pop requires filled already set.
- Protocol violations (bench asserts; RTL behaviour undefined):
  - issue while !ld_issue_ready;
  - ld_resp_valid with no unfilled entry;
  - alu_valid with busy[alu_rd]==1 and alu_rd!=0 (WAW hazard, prevented by the issue stage).

Decomposition:
- Shared header riscv_defs holds:
  - XLEN;
  - REG_ADDR_W=5;
  - NUM_REGS=32;
  - ZERO_REG=5'd0.
- Sub-module wb_load_queue: circular buffer with tail, fill and head pointers, count, filled flags, and a per-entry rd vector for the scoreboard.
- wb_arbiter holds the priority mux, the output register and the busy OR-reduction.

Test Plan:
1. ALU only: alu_valid, rd=5, wd=0xDEADBEEF at edge 0 -> rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF after edge 1; busy[5]=1 only during that cycle; rf_we=0 after edge 2.
2. Load path, x7:
   - Issue at edge 0 -> busy[7]=1, lq_count=1.
   - Response 0x12345678 at edge 3 -> rf_we=1, rf_rd=7 after edge 4.
   - lq_count=0 after edge 4; busy[7]=0 after edge 5.
3. Contention: filled head rd=9 while alu_valid held for 3 cycles (rd=1,2,3) -> ALU writes x1, x2, x3 back-to-back; x9 written in the first cycle after alu_valid drops.
4. Full queue:
   - Issue 4 loads (rd=10..13) -> ld_issue_ready=0 with lq_count=4.
   - Responses A, B, C, D -> written to x10..x13 in order with matching data.
   - ld_issue_ready=1 after the first pop.
5. x0 and overlap:
   - Load to x0 plus response -> rf_we never asserts; busy stays 0; lq_count returns to 0.
   - Issue and response on the same cycle with 1 outstanding entry -> data goes to the older entry.
6. Reset mid-operation: 3 loads pending, 1 filled, assert rst asynchronously between edges -> rf_we, busy and lq_count are 0 immediately; ld_issue_ready=1; no writes after rst deasserts.
